// File: rtl/counter_4bit_if.sv
// Control and status bundle for counter_4bit.
// master drives the controls and observes the count; slave is the counter itself.
interface counter_4bit_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;

  modport master (
    output en, clr, load, load_val, up_dn,
    input  out, tc, wrap
  );

  modport slave (
    input  en, clr, load, load_val, up_dn,
    output out, tc, wrap
  );
endinterface

// File: rtl/counter_4bit.sv
// Up/down binary counter with async active-low reset, sync clear, load, enable,
// combinational terminal count and a registered one-cycle wrap pulse.
module counter_4bit #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  counter_4bit_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic             wrap_q;

  // Wrap is flagged from the pre-update count, so it appears alongside the wrapped value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= RESET_VAL;
      wrap_q <= 1'b0;
    end else if (bus.clr) begin
      count  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      count  <= bus.load_val;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        count  <= count + ONE;
        wrap_q <= (count == MAX_VAL);
      end else begin
        count  <= count - ONE;
        wrap_q <= (count == '0);
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.out  = count;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.up_dn ? (count == MAX_VAL) : (count == '0);
endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit: directed reset/rollover sequences,
// a vector table, and randomized stimulus against an arithmetic reference model.
module tb_counter_4bit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  counter_4bit_if #(.WIDTH(4)) bus ();

  counter_4bit #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] loadVal;
    logic       upDn;
    logic [3:0] expOut;
    logic       expWrap;
    logic       expTc;
  } vector_t;

  vector_t vectors[10];

  task automatic checkOutput(input string name, input logic [3:0] expOut,
                             input logic expWrap, input logic expTc);
    testsRun++;
    if (bus.out !== expOut || bus.wrap !== expWrap || bus.tc !== expTc) begin
      testsFailed++;
      $display("[TB] FAIL %s: got out=%0d wrap=%b tc=%b, expected out=%0d wrap=%b tc=%b",
               name, bus.out, bus.wrap, bus.tc, expOut, expWrap, expTc);
    end
  endtask

  // Drive inputs away from the edge, clock once, then sample just after the edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic load,
                               input logic [3:0] loadVal, input logic upDn);
    bus.en       = en;
    bus.clr      = clr;
    bus.load     = load;
    bus.load_val = loadVal;
    bus.up_dn    = upDn;
    @(posedge clk);
    #1;
  endtask

  int modelOut;
  int sum;
  logic modelWrap;

  initial begin
    bus.en = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 4'd0; bus.up_dn = 1'b1;

    #1 checkOutput("reset_immediate", 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_hold", 4'd0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("release_no_change", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 checkOutput("first_edge", 4'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("count_up_%0d", i), 4'(i), 1'b0, (i == 15));
    end
    @(posedge clk);
    #1 checkOutput("rollover", 4'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1 checkOutput("wrap_one_cycle", 4'd1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1 checkOutput("count_to_5", 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("async_reset_midcount", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 checkOutput("after_midcount_release", 4'd1, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    checkOutput("load_9", 4'd9, 1'b0, 1'b0);
    for (int i = 8; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput($sformatf("count_down_%0d", i), 4'(i), 1'b0, (i == 0));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("down_wrap", 4'd15, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
      checkOutput($sformatf("en_low_hold_%0d", i), 4'd15, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 1'b1);
    checkOutput("clr_beats_load", 4'd0, 1'b0, 1'b0);

    // Vectors start from out=0 left by the clear above.
    vectors[0] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 1'b0};
    vectors[1] = '{1'b1, 1'b0, 1'b1, 4'd9,  1'b1, 4'd9,  1'b0, 1'b0};
    vectors[2] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd8,  1'b0, 1'b0};
    vectors[3] = '{1'b0, 1'b1, 1'b1, 4'd7,  1'b1, 4'd0,  1'b0, 1'b0};
    vectors[4] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd15, 1'b1, 1'b0};
    vectors[5] = '{1'b0, 1'b0, 1'b0, 4'd2,  1'b1, 4'd15, 1'b0, 1'b1};
    vectors[6] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
    vectors[7] = '{1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1};
    vectors[8] = '{1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 1'b1};
    vectors[9] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
    foreach (vectors[i]) begin
      applyStimulus(vectors[i].en, vectors[i].clr, vectors[i].load,
                    vectors[i].loadVal, vectors[i].upDn);
      checkOutput($sformatf("vector_%0d", i), vectors[i].expOut,
                  vectors[i].expWrap, vectors[i].expTc);
    end

    // Reference model: signed step, out-of-range sum means a wrap, then reduce mod 16.
    modelOut = 0;
    for (int n = 0; n < 300; n++) begin
      logic en, clr, load, upDn;
      logic [3:0] lv;
      en   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 9) == 0);
      upDn = $urandom_range(0, 1);
      lv   = 4'($urandom_range(0, 15));
      if (clr) begin
        modelOut = 0; modelWrap = 1'b0;
      end else if (load) begin
        modelOut = lv; modelWrap = 1'b0;
      end else if (en) begin
        sum = modelOut + (upDn ? 1 : -1);
        modelWrap = (sum < 0) || (sum > 15);
        modelOut = (sum + 16) % 16;
      end else begin
        modelWrap = 1'b0;
      end
      applyStimulus(en, clr, load, lv, upDn);
      checkOutput($sformatf("random_%0d", n), 4'(modelOut), modelWrap,
                  upDn ? (modelOut == 15) : (modelOut == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
